// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer and
// the hazard detectors that feed it.
package pipeline_ctrl_pkg;

   localparam int REG_AW = 5;
   localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } ctrl_state_t;

   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic id_ex_en;
      logic ex_mem_en;
      logic mem_wb_en;
      logic if_id_flush;
      logic id_ex_flush;
      logic mem_wb_bubble;
   } pipe_ctrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard detector: the ID instruction reads a register that the load
// in EX has not yet produced. Writes to x0 never create a dependency.
module load_use_detect
   import pipeline_ctrl_pkg::*;
(
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_mem_read,
   output logic              hazard
);

   assign hazard = ex_mem_read && (ex_rd != ZERO_REG) &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                    (id_use_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, taken-branch
// flushes, multi-cycle data-memory waits with timeout, and a stall counter.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   RUN      | normal flow; load-use stalls and branch flushes applied
//   MEM_WAIT | MEM access outstanding; front end frozen, WB gets bubbles
//   ERR      | memory timed out; pipeline frozen until reset
module pipeline_hazard_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_mem_read,
   input  logic              ex_branch_taken,
   input  logic              mem_req,
   input  logic              mem_ready,
   output logic              pc_en,
   output logic              if_id_en,
   output logic              id_ex_en,
   output logic              ex_mem_en,
   output logic              mem_wb_en,
   output logic              if_id_flush,
   output logic              id_ex_flush,
   output logic              mem_wb_bubble,
   output logic              mem_timeout,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   ctrl_state_t       state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0]  stall_q, stall_d;
   logic              load_use;
   pipe_ctrl_t        hold_ctrl, adv_ctrl, ctrl;

   load_use_detect u_load_use_detect (
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_use_rs1  (id_use_rs1),
      .id_use_rs2  (id_use_rs2),
      .ex_rd       (ex_rd),
      .ex_mem_read (ex_mem_read),
      .hazard      (load_use)
   );

   // Memory hold: retire WB but insert a bubble so the stalled MEM op is not written twice.
   always_comb begin
      hold_ctrl               = '0;
      hold_ctrl.mem_wb_en     = 1'b1;
      hold_ctrl.mem_wb_bubble = 1'b1;
   end

   // Advancing cycle: branch squash beats load-use since the ID op is discarded anyway.
   always_comb begin
      adv_ctrl = '0;
      if (ex_branch_taken) begin
         adv_ctrl             = '1;
         adv_ctrl.mem_wb_bubble = 1'b0;
      end else if (load_use) begin
         adv_ctrl.id_ex_en    = 1'b1;
         adv_ctrl.id_ex_flush = 1'b1;
         adv_ctrl.ex_mem_en   = 1'b1;
         adv_ctrl.mem_wb_en   = 1'b1;
      end else begin
         adv_ctrl.pc_en     = 1'b1;
         adv_ctrl.if_id_en  = 1'b1;
         adv_ctrl.id_ex_en  = 1'b1;
         adv_ctrl.ex_mem_en = 1'b1;
         adv_ctrl.mem_wb_en = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      ctrl    = '0;
      case (state_q)
         RUN: begin
            if (mem_req && !mem_ready) begin
               ctrl    = hold_ctrl;
               state_d = MEM_WAIT;
               wait_d  = WAIT_W'(1);
            end else begin
               ctrl = adv_ctrl;
            end
         end
         MEM_WAIT: begin
            if (!mem_ready) begin
               ctrl = hold_ctrl;
               if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                  state_d = ERR;
               end else begin
                  wait_d = wait_q + 1'b1;
               end
            end else begin
               ctrl    = adv_ctrl;
               state_d = RUN;
               wait_d  = '0;
            end
         end
         ERR: begin
            ctrl = '0;
         end
         default: begin
            state_d = RUN;
            wait_d  = '0;
         end
      endcase
      // Outputs are Mealy, so reset must mask them combinationally too.
      if (rst) begin
         ctrl = '0;
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (!ctrl.pc_en && (stall_q != {CNT_W{1'b1}})) begin
         stall_d = stall_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         wait_q  <= '0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         stall_q <= stall_d;
      end
   end

   assign pc_en         = ctrl.pc_en;
   assign if_id_en      = ctrl.if_id_en;
   assign id_ex_en      = ctrl.id_ex_en;
   assign ex_mem_en     = ctrl.ex_mem_en;
   assign mem_wb_en     = ctrl.mem_wb_en;
   assign if_id_flush   = ctrl.if_id_flush;
   assign id_ex_flush   = ctrl.id_ex_flush;
   assign mem_wb_bubble = ctrl.mem_wb_bubble;
   assign mem_timeout   = (state_q == ERR);
   assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; control outputs are compared as one
// vector {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id_flush, id_ex_flush, bubble}.
module tb_pipeline_hazard_ctrl;

   localparam int CNT_W = 5;

   logic       clk, rst;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
   logic       mem_req, mem_ready;
   logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic       if_id_flush, id_ex_flush, mem_wb_bubble, mem_timeout;
   logic [CNT_W-1:0] stall_cnt;
   logic [7:0] ctrl_v;

   int n_cmp = 0;
   int n_err = 0;

   pipeline_hazard_ctrl #(.TIMEOUT(16), .CNT_W(CNT_W)) dut (
      .clk             (clk),
      .rst             (rst),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_use_rs1      (id_use_rs1),
      .id_use_rs2      (id_use_rs2),
      .ex_rd           (ex_rd),
      .ex_mem_read     (ex_mem_read),
      .ex_branch_taken (ex_branch_taken),
      .mem_req         (mem_req),
      .mem_ready       (mem_ready),
      .pc_en           (pc_en),
      .if_id_en        (if_id_en),
      .id_ex_en        (id_ex_en),
      .ex_mem_en       (ex_mem_en),
      .mem_wb_en       (mem_wb_en),
      .if_id_flush     (if_id_flush),
      .id_ex_flush     (id_ex_flush),
      .mem_wb_bubble   (mem_wb_bubble),
      .mem_timeout     (mem_timeout),
      .stall_cnt       (stall_cnt)
   );

   assign ctrl_v = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                    if_id_flush, id_ex_flush, mem_wb_bubble};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   localparam logic [7:0] C_IDLE = 8'hF8;
   localparam logic [7:0] C_LU   = 8'h3A;
   localparam logic [7:0] C_HOLD = 8'h09;
   localparam logic [7:0] C_BR   = 8'hFE;
   localparam logic [7:0] C_OFF  = 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_in();
      id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
      id_use_rs1 = 0; id_use_rs2 = 0; ex_mem_read = 0; ex_branch_taken = 0;
      mem_req = 0; mem_ready = 0;
   endtask

   initial begin
      rst = 1'b1;
      clear_in();
      #1;
      chk("rst_ctrl", 32'(ctrl_v), 32'(C_OFF));
      chk("rst_stall", 32'(stall_cnt), 0);
      chk("rst_timeout", 32'(mem_timeout), 0);
      cyc();
      chk("rst_stall_hold", 32'(stall_cnt), 0);
      rst = 1'b0;
      #1 chk("idle", 32'(ctrl_v), 32'(C_IDLE));
      cyc();
      chk("idle_stall", 32'(stall_cnt), 0);

      // load-use via rs1
      ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
      #1 chk("lu_rs1", 32'(ctrl_v), 32'(C_LU));
      cyc();
      ex_mem_read = 0;
      #1 chk("lu_clear", 32'(ctrl_v), 32'(C_IDLE));
      chk("lu_stall", 32'(stall_cnt), 1);
      cyc();

      // register match without a use flag is not a hazard; then via rs2
      clear_in();
      ex_mem_read = 1; ex_rd = 9; id_rs1 = 9; id_rs2 = 9;
      #1 chk("lu_unused", 32'(ctrl_v), 32'(C_IDLE));
      id_use_rs2 = 1;
      #1 chk("lu_rs2", 32'(ctrl_v), 32'(C_LU));
      cyc();

      // x0 destination never stalls
      clear_in();
      ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
      #1 chk("x0", 32'(ctrl_v), 32'(C_IDLE));
      chk("x0_stall", 32'(stall_cnt), 2);

      // branch beats load-use
      ex_rd = 7; id_rs1 = 7; ex_branch_taken = 1;
      #1 chk("br_lu", 32'(ctrl_v), 32'(C_BR));
      cyc();
      clear_in();
      chk("br_stall", 32'(stall_cnt), 2);

      // three-cycle memory wait
      mem_req = 1;
      #1 chk("mw_entry", 32'(ctrl_v), 32'(C_HOLD));
      cyc();
      chk("mw_1", 32'(ctrl_v), 32'(C_HOLD));
      chk("mw_1_stall", 32'(stall_cnt), 3);
      cyc();
      chk("mw_2", 32'(ctrl_v), 32'(C_HOLD));
      cyc();
      mem_ready = 1;
      #1 chk("mw_ready", 32'(ctrl_v), 32'(C_IDLE));
      chk("mw_ready_stall", 32'(stall_cnt), 5);
      cyc();
      clear_in();
      #1 chk("mw_run", 32'(ctrl_v), 32'(C_IDLE));

      // single-cycle access in RUN
      mem_req = 1; mem_ready = 1;
      #1 chk("mem_single", 32'(ctrl_v), 32'(C_IDLE));
      cyc();
      chk("mem_single_stall", 32'(stall_cnt), 5);

      // branch deferred through a 2-cycle wait
      clear_in();
      mem_req = 1; ex_branch_taken = 1;
      #1 chk("db_entry", 32'(ctrl_v), 32'(C_HOLD));
      cyc();
      chk("db_wait", 32'(ctrl_v), 32'(C_HOLD));
      cyc();
      mem_ready = 1;
      #1 chk("db_ready", 32'(ctrl_v), 32'(C_BR));
      cyc();
      chk("db_stall", 32'(stall_cnt), 7);

      // load-use deferred through a 1-cycle wait
      clear_in();
      mem_req = 1; ex_mem_read = 1; ex_rd = 3; id_rs2 = 3; id_use_rs2 = 1;
      #1 chk("dl_entry", 32'(ctrl_v), 32'(C_HOLD));
      cyc();
      mem_ready = 1;
      #1 chk("dl_ready", 32'(ctrl_v), 32'(C_LU));
      cyc();
      chk("dl_stall", 32'(stall_cnt), 9);
      clear_in();
      #1 chk("dl_run", 32'(ctrl_v), 32'(C_IDLE));

      // timeout: entry cycle plus 15 waiting cycles
      mem_req = 1;
      #1 chk("to_entry", 32'(ctrl_v), 32'(C_HOLD));
      cyc();
      for (int i = 1; i <= 15; i++) begin
         chk("to_wait", 32'(ctrl_v), 32'(C_HOLD));
         chk("to_wait_flag", 32'(mem_timeout), 0);
         cyc();
      end
      chk("to_err", 32'(ctrl_v), 32'(C_OFF));
      chk("to_flag", 32'(mem_timeout), 1);
      chk("to_stall", 32'(stall_cnt), 25);
      mem_ready = 1;
      #1 chk("err_ready", 32'(ctrl_v), 32'(C_OFF));
      cyc();
      cyc();
      chk("err_flag", 32'(mem_timeout), 1);
      chk("err_stall", 32'(stall_cnt), 27);
      for (int i = 0; i < 4; i++) cyc();
      chk("stall_sat", 32'(stall_cnt), 31);
      cyc();
      cyc();
      chk("stall_hold", 32'(stall_cnt), 31);
      chk("err_ctrl", 32'(ctrl_v), 32'(C_OFF));

      // reset out of ERR
      rst = 1;
      #1 chk("rst_err_flag", 32'(mem_timeout), 0);
      chk("rst_err_stall", 32'(stall_cnt), 0);
      cyc();
      rst = 0;
      clear_in();
      #1 chk("rel_err", 32'(ctrl_v), 32'(C_IDLE));
      cyc();

      // async reset in the middle of MEM_WAIT
      mem_req = 1;
      cyc();
      cyc();
      chk("ar_pre_stall", 32'(stall_cnt), 2);
      chk("ar_pre_ctrl", 32'(ctrl_v), 32'(C_HOLD));
      #1 rst = 1;
      #1 chk("ar_ctrl", 32'(ctrl_v), 32'(C_OFF));
      chk("ar_stall", 32'(stall_cnt), 0);
      chk("ar_flag", 32'(mem_timeout), 0);
      cyc();
      rst = 0;
      mem_req = 0;
      #1 chk("ar_first", 32'(ctrl_v), 32'(C_IDLE));
      cyc();
      chk("ar_stall_after", 32'(stall_cnt), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
